// File: rtl/btb_predictor_if.sv
// Lookup, update and statistics signals shared between the fetch/execute pipeline and the BTB.
// The update port is valid-only: an update is taken on every rising edge where upd_valid=1 (no ready, never back-pressured).
interface btb_predictor_if #(
  parameter int IDX_W = 3
);
  logic [31:0]      if_pc;
  logic [31:0]      pred_pc;
  logic [IDX_W-1:0] pred_hitpos;
  logic             pred_hit;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_hit;
  logic [IDX_W-1:0] upd_hitpos;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispred;
  logic [31:0]      stat_branch;
  logic [31:0]      stat_mispred;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_hit, upd_hitpos, upd_taken, upd_target, upd_mispred,
    input  pred_pc, pred_hitpos, pred_hit, stat_branch, stat_mispred
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_hit, upd_hitpos, upd_taken, upd_target, upd_mispred,
    output pred_pc, pred_hitpos, pred_hit, stat_branch, stat_mispred
  );
endinterface

// File: rtl/btb_predictor.sv
// Fully associative branch target buffer with 2-bit saturating direction counters,
// round-robin replacement once full, and branch/mispredict statistics.
module btb_predictor #(
  parameter int         DEPTH   = 8,
  parameter int         IDX_W   = 3,
  parameter logic [1:0] CTR_INI = 2'b10
) (
  input logic             clk,
  input logic             rst,
  btb_predictor_if.slave  bus
);

  logic [DEPTH-1:0] valid;
  logic [31:0]      tag    [DEPTH];
  logic [31:0]      target [DEPTH];
  logic [1:0]       ctr    [DEPTH];
  logic [IDX_W-1:0] rr_ptr;

  logic             look_hit;
  logic [IDX_W-1:0] look_idx;

  logic             hint_ok;
  logic             srch_hit;
  logic [IDX_W-1:0] srch_idx;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             do_train;
  logic             do_alloc;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] alloc_idx;

  // Lookup reads only registered state; descending scan lets the lowest index win.
  always_comb begin
    look_hit = 1'b0;
    look_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == bus.if_pc)) begin
        look_hit = 1'b1;
        look_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    bus.pred_hit    = look_hit;
    bus.pred_hitpos = look_idx;
    if (look_hit && ctr[look_idx][1]) begin
      bus.pred_pc = target[look_idx];
    end else begin
      bus.pred_pc = bus.if_pc + 32'd1;
    end
  end

  // Update-side entry selection: trust the carried hitpos only if it still names this PC.
  always_comb begin
    hint_ok  = bus.upd_hit && valid[bus.upd_hitpos] && (tag[bus.upd_hitpos] == bus.upd_pc);
    srch_hit = 1'b0;
    srch_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == bus.upd_pc)) begin
        srch_hit = 1'b1;
        srch_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    do_train  = 1'b0;
    do_alloc  = 1'b0;
    sel_idx   = '0;
    alloc_idx = free_any ? free_idx : rr_ptr;
    if (bus.upd_valid) begin
      if (hint_ok) begin
        do_train = 1'b1;
        sel_idx  = bus.upd_hitpos;
      end else if (srch_hit) begin
        do_train = 1'b1;
        sel_idx  = srch_idx;
      end else if (bus.upd_taken) begin
        do_alloc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid            <= '0;
      rr_ptr           <= '0;
      bus.stat_branch  <= '0;
      bus.stat_mispred <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= '0;
      end
    end else begin
      if (bus.upd_valid) begin
        bus.stat_branch <= bus.stat_branch + 32'd1;
        if (bus.upd_mispred) begin
          bus.stat_mispred <= bus.stat_mispred + 32'd1;
        end
      end
      if (do_train) begin
        if (bus.upd_taken) begin
          target[sel_idx] <= bus.upd_target;
          if (ctr[sel_idx] != 2'd3) begin
            ctr[sel_idx] <= ctr[sel_idx] + 2'd1;
          end
        end else if (ctr[sel_idx] != 2'd0) begin
          ctr[sel_idx] <= ctr[sel_idx] - 2'd1;
        end
      end
      if (do_alloc) begin
        valid[alloc_idx]  <= 1'b1;
        tag[alloc_idx]    <= bus.upd_pc;
        target[alloc_idx] <= bus.upd_target;
        ctr[alloc_idx]    <= CTR_INI;
        // The pointer only advances when a live entry is actually displaced.
        if (!free_any) begin
          rr_ptr <= rr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed and randomized bench for btb_predictor against a behavioural table model.
module tb_btb_predictor;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  btb_predictor_if #(.IDX_W(IDX_W)) bus ();

  btb_predictor #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CTR_INI(2'b10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: a list of slots, each either empty or holding a branch
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          m_rr;
  logic [31:0] m_branch;
  logic [31:0] m_mispred;
  logic [31:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 0;
    end
    m_rr      = 0;
    m_branch  = '0;
    m_mispred = '0;
  endtask

  function automatic int model_find(input logic [31:0] pc);
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic model_update(input logic v, input logic [31:0] pc, input logic h,
                              input int hp, input logic tk, input logic [31:0] tgt,
                              input logic mis);
    int e;
    int fr;
    if (!v) return;
    m_branch = m_branch + 1;
    if (mis) m_mispred = m_mispred + 1;
    if (h && m_valid[hp] && m_tag[hp] == pc) e = hp;
    else e = model_find(pc);
    if (e >= 0) begin
      if (tk) begin
        m_ctr[e] = (m_ctr[e] == 3) ? 3 : m_ctr[e] + 1;
        m_tgt[e] = tgt;
      end else begin
        m_ctr[e] = (m_ctr[e] == 0) ? 0 : m_ctr[e] - 1;
      end
    end else if (tk) begin
      fr = -1;
      for (int i = DEPTH - 1; i >= 0; i--)
        if (!m_valid[i]) fr = i;
      if (fr < 0) begin
        fr   = m_rr;
        m_rr = (m_rr + 1) % DEPTH;
      end
      m_valid[fr] = 1;
      m_tag[fr]   = pc;
      m_tgt[fr]   = tgt;
      m_ctr[fr]   = 2;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_lookup();
    int          e;
    logic [31:0] exp_pc;
    e = model_find(bus.if_pc);
    exp_pc = (e >= 0 && m_ctr[e] >= 2) ? m_tgt[e] : bus.if_pc + 32'd1;
    exp_q.push_back(exp_pc);
    check("pred_hit", {31'd0, bus.pred_hit}, (e >= 0) ? 32'd1 : 32'd0);
    check("pred_hitpos", {29'd0, bus.pred_hitpos}, (e >= 0) ? 32'(e) : 32'd0);
    check("pred_pc", bus.pred_pc, exp_q.pop_front());
  endtask

  task automatic check_stats();
    check("stat_branch", bus.stat_branch, m_branch);
    check("stat_mispred", bus.stat_mispred, m_mispred);
  endtask

  // driver: called just after a falling edge; lookup checked before the rising edge
  task automatic step(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                      input logic h, input int hp, input logic tk,
                      input logic [31:0] tgt, input logic mis);
    bus.if_pc       = ipc;
    bus.upd_valid   = v;
    bus.upd_pc      = pc;
    bus.upd_hit     = h;
    bus.upd_hitpos  = IDX_W'(hp);
    bus.upd_taken   = tk;
    bus.upd_target  = tgt;
    bus.upd_mispred = mis;
    #1;
    check_lookup();
    @(posedge clk);
    model_update(v, pc, h, hp, tk, tgt, mis);
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    step(pc, 1'b1, pc, 1'b0, 0, tk, tgt, 1'b0);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(ipc, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.if_pc = 32'h10;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_hit = 1'b0; bus.upd_hitpos = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispred = 1'b0;
    model_reset();

    // 1: reset state
    #2;
    check("rst_hit", {31'd0, bus.pred_hit}, 32'd0);
    check("rst_hitpos", {29'd0, bus.pred_hitpos}, 32'd0);
    check("rst_pred_pc", bus.pred_pc, 32'h11);
    @(negedge clk);
    rst = 1'b1;
    check_stats();
    idle(32'h10);

    // 2: cold allocate
    upd(32'h20, 1'b1, 32'h40);
    idle(32'h20);
    check("alloc_pred_pc", bus.pred_pc, 32'h40);

    // 3: saturation both ways
    step(32'h20, 1'b1, 32'h20, 1'b1, 0, 1'b1, 32'h40, 1'b0);
    step(32'h20, 1'b1, 32'h20, 1'b1, 0, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 4; i++) step(32'h20, 1'b1, 32'h20, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    idle(32'h20);
    check("sat_low_pc", bus.pred_pc, 32'h21);
    upd(32'h20, 1'b1, 32'h40);
    idle(32'h20);
    check("sat_low_stays", bus.pred_pc, 32'h21);

    // 4: fill then round-robin evict
    do_reset();
    for (int i = 0; i < DEPTH; i++) upd(32'h100 + i, 1'b1, 32'h500 + i);
    upd(32'h200, 1'b1, 32'h600);
    idle(32'h100);
    check("evict_miss", {31'd0, bus.pred_hit}, 32'd0);
    idle(32'h200);
    check("evict_pos", {29'd0, bus.pred_hitpos}, 32'd0);
    upd(32'h300, 1'b1, 32'h700);
    idle(32'h101);
    check("evict2_miss", {31'd0, bus.pred_hit}, 32'd0);

    // 5: same-cycle lookup/update, then a stale hitpos
    bus.if_pc = 32'h30;
    #1;
    check("same_cycle_hit", {31'd0, bus.pred_hit}, 32'd0);
    step(32'h30, 1'b1, 32'h30, 1'b0, 0, 1'b1, 32'h44, 1'b0);
    idle(32'h30);
    check("next_cycle_hit", {31'd0, bus.pred_hit}, 32'd1);
    step(32'h30, 1'b1, 32'h30, 1'b1, 5, 1'b1, 32'h88, 1'b0);
    idle(32'h30);
    check("stale_trained", bus.pred_pc, 32'h88);
    idle(32'h105);
    check("stale_untouched", bus.pred_pc, 32'h505);

    // 6: stats, ignored mispred, async reset, reset beating a pending update
    do_reset();
    for (int i = 0; i < 5; i++)
      step(32'h0, 1'b1, 32'h800 + i, 1'b0, 0, 1'b1, 32'h900, (i % 2 == 1));
    step(32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    check("stat5_branch", bus.stat_branch, 32'd5);
    check("stat2_mispred", bus.stat_mispred, 32'd2);
    bus.if_pc = 32'h800;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'hA00; bus.upd_hit = 1'b0;
    bus.upd_taken = 1'b1; bus.upd_target = 32'hB00; bus.upd_mispred = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_branch", bus.stat_branch, 32'd0);
    check("async_mispred", bus.stat_mispred, 32'd0);
    check("async_hit", {31'd0, bus.pred_hit}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(32'hA00);
    check_stats();

    // randomized traffic over a small PC pool to force hits, stale hints and evictions
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      int          e;
      logic        h;
      int          hp;
      pc = 32'h1000 + $urandom_range(0, 11);
      e  = model_find(pc);
      h  = $urandom_range(0, 1);
      hp = (e >= 0 && $urandom_range(0, 3) != 0) ? e : $urandom_range(0, DEPTH - 1);
      step(32'h1000 + $urandom_range(0, 11), $urandom_range(0, 3) != 0, pc, h, hp,
           $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1));
      if (n % 50 == 49) check_stats();
    end
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
